// File: rtl/axi_lite_gpio_if.sv
// AXI4-Lite slave-side bus bundle for the GPIO peripheral.
// The master modport is the CPU-side bridge; the slave modport is the peripheral.
interface axi_lite_gpio_if;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );
endinterface

// File: rtl/axi_lite_gpio.sv
// AXI4-Lite GPIO: DATA/DIR registers, 2-flop input sync; write resp 1 cycle after AW+W, read data 1 cycle after AR.
// Responses held until BREADY/RREADY; optional edge-detect interrupt under GPIO_IRQ_EN.
module axi_lite_gpio #(
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_lite_gpio_if.slave        s_axi,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  gpio_irq
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                  aw_held, w_held;
  logic [31:0]           awaddr_q, wdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;
  logic [GPIO_WIDTH-1:0] out_q, dir_q, sync1, sync2;
  logic [GPIO_WIDTH-1:0] stat_rd, mask_rd;

  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                  do_write, wr_ok, rd_ok;
  logic [31:0]           wr_addr, wr_data, wr_mask32;
  logic [3:0]            wr_strb;
  logic [GPIO_WIDTH-1:0] wr_mask, wr_bits, rd_sel;

  // 0x8/0xC only exist when the interrupt block is built.
  function automatic logic is_mapped(input logic [31:0] a);
    logic m;
    m = (a[31:4] == 28'd0) && (a[1:0] == 2'b00);
`ifndef GPIO_IRQ_EN
    m = m && !a[3];
`endif
    return m;
  endfunction

  assign s_axi.S_AXI_AWREADY = reset && (w_state == W_IDLE) && !aw_held;
  assign s_axi.S_AXI_WREADY  = reset && (w_state == W_IDLE) && !w_held;
  assign s_axi.S_AXI_ARREADY = reset && (r_state == R_IDLE);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign b_hs  = (w_state == W_RESP) && s_axi.S_AXI_BREADY;
  assign r_hs  = (r_state == R_DATA) && s_axi.S_AXI_RREADY;

  // Take each half from its latch if it arrived earlier, else straight off the bus.
  assign do_write  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr   = aw_held ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign wr_data   = w_held  ? wdata_q  : s_axi.S_AXI_WDATA;
  assign wr_strb   = w_held  ? wstrb_q  : s_axi.S_AXI_WSTRB;
  assign wr_ok     = is_mapped(wr_addr);
  assign wr_mask32 = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign wr_mask   = wr_mask32[GPIO_WIDTH-1:0];
  assign wr_bits   = wr_data[GPIO_WIDTH-1:0];
  assign rd_ok     = is_mapped(s_axi.S_AXI_ARADDR);

  always_comb begin
    w_state_nxt = w_state;
    r_state_nxt = r_state;
    s_axi.S_AXI_BVALID = (w_state == W_RESP);
    s_axi.S_AXI_RVALID = (r_state == R_DATA);
    case (w_state)
      W_IDLE:  if (do_write) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs)     w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_sel = '0;
    case (s_axi.S_AXI_ARADDR[3:2])
      2'd0:    rd_sel = sync2;
      2'd1:    rd_sel = dir_q;
      2'd2:    rd_sel = stat_rd;
      default: rd_sel = mask_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      out_q    <= '0;
      dir_q    <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      sync1   <= gpio_in;
      sync2   <= sync1;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (do_write) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok && wr_addr[3:2] == 2'd0) out_q <= (out_q & ~wr_mask) | (wr_bits & wr_mask);
        if (wr_ok && wr_addr[3:2] == 2'd1) dir_q <= (dir_q & ~wr_mask) | (wr_bits & wr_mask);
      end
      if (ar_hs) begin
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= rd_ok ? 32'(rd_sel) : 32'd0;
      end
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] sync3, stat_q, mask_q, stat_clr;
  logic                  irq_q;

  assign stat_clr = (do_write && wr_ok && wr_addr[3:2] == 2'd2) ? (wr_bits & wr_mask) : '0;

  // A new rising edge overrides a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync3  <= '0;
      stat_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync3  <= sync2;
      stat_q <= (stat_q & ~stat_clr) | (sync2 & ~sync3);
      if (do_write && wr_ok && wr_addr[3:2] == 2'd3) mask_q <= (mask_q & ~wr_mask) | (wr_bits & wr_mask);
      irq_q  <= |(stat_q & mask_q);
    end
  end

  assign stat_rd  = stat_q;
  assign mask_rd  = mask_q;
  assign gpio_irq = irq_q;
`else
  assign stat_rd  = '0;
  assign mask_rd  = '0;
  assign gpio_irq = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wr_data};

endmodule

// File: tb/tb_axi_lite_gpio.sv
// Directed bench for axi_lite_gpio (GPIO_WIDTH=8); interrupt checks follow GPIO_IRQ_EN.
module tb_axi_lite_gpio;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out, gpio_oe;
  logic       gpio_irq;
  int         errors = 0;
  int         checks = 0;

  axi_lite_gpio_if bus ();

  axi_lite_gpio #(.GPIO_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_axi    (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .gpio_irq (gpio_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // AW presented at once; W presented wd cycles later (0 = together). cyc counts edges from start to BVALID.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int wd, output logic [1:0] resp, output int cyc);
    int  k;
    logic aw_go, w_go;
    k = 0;
    cyc = -1;
    resp = 2'bxx;
    @(negedge clk);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = (wd == 0);
    bus.S_AXI_BREADY  = 1'b1;
    while (k < 30) begin
      aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge clk);
      k++;
      if (aw_go) bus.S_AXI_AWVALID = 1'b0;
      if (w_go)  bus.S_AXI_WVALID  = 1'b0;
      if (k == wd) bus.S_AXI_WVALID = 1'b1;
      if (bus.S_AXI_BVALID) begin
        resp = bus.S_AXI_BRESP;
        cyc  = k;
        break;
      end
    end
    @(negedge clk);
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("write_completes", 32'(cyc >= 0), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int cyc);
    int   k;
    logic ar_go;
    k = 0;
    cyc = -1;
    d = 'x;
    resp = 2'bxx;
    @(negedge clk);
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    while (k < 30) begin
      ar_go = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(negedge clk);
      k++;
      if (ar_go) bus.S_AXI_ARVALID = 1'b0;
      if (bus.S_AXI_RVALID) begin
        d    = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        cyc  = k;
        break;
      end
    end
    @(negedge clk);
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    check("read_completes", 32'(cyc >= 0), 32'd1);
  endtask

  initial begin
    logic [1:0]  bresp, rresp;
    logic [31:0] rdat;
    int          bcyc, rcyc;

    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0;
    bus.S_AXI_WVALID  = 1'b0; bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
    bus.S_AXI_RREADY  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
    check("rst_out",     32'(gpio_out),          32'd0);
    check("rst_oe",      32'(gpio_oe),           32'd0);
    check("rst_irq",     32'(gpio_irq),          32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("idle_arready", 32'(bus.S_AXI_ARREADY), 32'd1);

    // Same-cycle AW+W: response one cycle later.
    axi_write(32'h0, 32'h0000_00A5, 4'hF, 0, bresp, bcyc);
    check("wr0_bresp", 32'(bresp), 32'd0);
    check("wr0_lat",   32'(bcyc),  32'd1);
    check("wr0_out",   32'(gpio_out), 32'hA5);

    axi_write(32'h4, 32'h0000_00FF, 4'hF, 0, bresp, bcyc);
    check("dir_oe", 32'(gpio_oe), 32'hFF);
    axi_write(32'h4, 32'h0000_0000, 4'h0, 0, bresp, bcyc);
    check("dir_nostrb_resp", 32'(bresp), 32'd0);
    check("dir_nostrb_oe",   32'(gpio_oe), 32'hFF);

    // Upper-byte strobes only touch bits that do not exist.
    axi_write(32'h0, 32'h5A5A_5A00, 4'hE, 0, bresp, bcyc);
    check("hi_strb_out", 32'(gpio_out), 32'hA5);

    // W two cycles after AW: BVALID in cycle 3.
    axi_write(32'h0, 32'h0000_003C, 4'h1, 2, bresp, bcyc);
    check("late_w_lat", 32'(bcyc), 32'd3);
    check("late_w_out", 32'(gpio_out), 32'h3C);

    axi_read(32'h4, rdat, rresp, rcyc);
    check("rd_dir_data", rdat, 32'hFF);
    check("rd_dir_resp", 32'(rresp), 32'd0);
    check("rd_dir_lat",  32'(rcyc), 32'd1);

    // Read with RREADY held low: data must sit still.
    gpio_in = 8'h3C;
    repeat (3) @(negedge clk);
    bus.S_AXI_ARADDR  = 32'h0;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    check("hold_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("hold_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
      check("hold_rdata",  bus.S_AXI_RDATA,       32'h3C);
      @(negedge clk);
    end
    bus.S_AXI_RREADY = 1'b1;
    check("hold_rvalid_final", 32'(bus.S_AXI_RVALID), 32'd1);
    @(negedge clk);
    check("hold_released", 32'(bus.S_AXI_RVALID), 32'd0);
    bus.S_AXI_RREADY = 1'b0;

    // Concurrent unmapped read and write.
    fork
      axi_write(32'h14, 32'h0000_0000, 4'hF, 0, bresp, bcyc);
      axi_read(32'h10, rdat, rresp, rcyc);
    join
    check("unm_bresp", 32'(bresp), 32'd2);
    check("unm_rresp", 32'(rresp), 32'd2);
    check("unm_rdata", rdat,       32'd0);
    check("unm_out",   32'(gpio_out), 32'h3C);
    check("unm_oe",    32'(gpio_oe),  32'hFF);
    axi_write(32'h2, 32'h0000_0000, 4'hF, 0, bresp, bcyc);
    check("unaligned_bresp", 32'(bresp), 32'd2);
    check("unaligned_out",   32'(gpio_out), 32'h3C);
    axi_write(32'h1000_0004, 32'h0000_0000, 4'hF, 0, bresp, bcyc);
    check("highaddr_bresp", 32'(bresp), 32'd2);
    check("highaddr_oe",    32'(gpio_oe), 32'hFF);

`ifdef GPIO_IRQ_EN
    axi_write(32'hC, 32'h0000_0001, 4'hF, 0, bresp, bcyc);
    check("mask_bresp", 32'(bresp), 32'd0);
    repeat (2) @(negedge clk);
    check("irq_masked", 32'(gpio_irq), 32'd0);
    gpio_in = 8'h3D;
    repeat (5) @(negedge clk);
    check("irq_set", 32'(gpio_irq), 32'd1);
    axi_read(32'h8, rdat, rresp, rcyc);
    check("stat_rd", rdat, 32'h3D);
    axi_write(32'h8, 32'h0000_0001, 4'hF, 0, bresp, bcyc);
    check("w1c_bresp", 32'(bresp), 32'd0);
    repeat (2) @(negedge clk);
    check("irq_clr", 32'(gpio_irq), 32'd0);
    axi_read(32'h8, rdat, rresp, rcyc);
    check("stat_after_clr", rdat, 32'h3C);
    axi_read(32'hC, rdat, rresp, rcyc);
    check("mask_rd", rdat, 32'h01);
`else
    axi_read(32'h8, rdat, rresp, rcyc);
    check("noirq_stat_resp", 32'(rresp), 32'd2);
    check("noirq_stat_data", rdat,       32'd0);
    axi_write(32'hC, 32'h0000_0001, 4'hF, 0, bresp, bcyc);
    check("noirq_mask_resp", 32'(bresp), 32'd2);
    gpio_in = 8'h3D;
    repeat (5) @(negedge clk);
    check("noirq_irq", 32'(gpio_irq), 32'd0);
`endif

    // Reset while BVALID is pending.
    @(negedge clk);
    bus.S_AXI_AWADDR  = 32'h0;
    bus.S_AXI_WDATA   = 32'h0000_0077;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b0;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("pend_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("pend_out",    32'(gpio_out),         32'h77);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("mid_rst_out",     32'(gpio_out),          32'd0);
    check("mid_rst_oe",      32'(gpio_oe),           32'd0);
    check("mid_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("post_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);

    // A held AW is dropped by reset; the next write uses the fresh address.
    bus.S_AXI_AWADDR  = 32'h4;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    axi_write(32'h0, 32'h0000_0011, 4'hF, 0, bresp, bcyc);
    check("discard_aw_lat", 32'(bcyc),     32'd1);
    check("discard_aw_oe",  32'(gpio_oe),  32'h00);
    check("discard_aw_out", 32'(gpio_out), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
